// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for an unclocked single-port RAM; every RAM pin is registered.
// Define RAM_ARBITER_ROUND_ROBIN_EN for alternating grants on ties (default: port 0 wins).
module ram_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              ack0_o,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              grant1;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // On a tie, hand the RAM to whichever port did not have it last.
  assign grant1 = req1_i & (~req0_i | ~last_owner_q);
`else
  assign grant1 = req1_i & ~req0_i;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0_i | req1_i) begin
          owner_d     = grant1;
          ram_addr_d  = grant1 ? addr1_i  : addr0_i;
          ram_wdata_d = grant1 ? wdata1_i : wdata0_i;
          ram_we_d    = grant1 ? we1_i    : we0_i;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        // RAM reads through on writes, so the owner always gets the addressed data back.
        if (owner_q) begin
          rdata1_d = ram_rdata_i;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = ram_rdata_i;
          ack0_d   = 1'b1;
        end
        state_d = StDone;
      end
      StDone: begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        last_owner_d = owner_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= 1'b1;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`endif

  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign ram_we_o    = ram_we_q;
  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and an ack-driven scoreboard.
// Grant-order expectations follow RAM_ARBITER_ROUND_ROBIN_EN when it is defined.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [4:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, ram_we, busy;
  logic [7:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [4:0] ram_addr;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  logic       mem_init = 1'b0;
  int         tests = 0, fails = 0, cyc = 0, we_cnt = 0;
  logic [7:0] hold0 = '0, hold1 = '0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_i     (req0),
    .we0_i      (we0),
    .addr0_i    (addr0),
    .wdata0_i   (wdata0),
    .ack0_o     (ack0),
    .rdata0_o   (rdata0),
    .req1_i     (req1),
    .we1_i      (we1),
    .addr1_i    (addr1),
    .wdata1_i   (wdata1),
    .ack1_o     (ack1),
    .rdata1_o   (rdata1),
    .ram_addr_o (ram_addr),
    .ram_wdata_o(ram_wdata),
    .ram_we_o   (ram_we),
    .ram_rdata_i(ram_rdata),
    .busy_o     (busy)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 13) ^ 8'h5A;
  endfunction

  // Unclocked RAM: combinational read-through, write lands while we is held.
  assign ram_rdata = ram_we ? ram_wdata : mem[ram_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack pops one entry and must match port and data.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold0 = '0;
      hold1 = '0;
    end else begin
      if (ram_we) we_cnt++;
      check("one_ack_only", 32'(ack0 & ack1), 32'd0);
      check("we_implies_busy", 32'(ram_we & ~busy), 32'd0);
      if (ack0 || ack1) begin
        check("ack_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("grant_port", ack1 ? 32'd1 : 32'd0, 32'(e.port));
          if (ack1) begin
            check("rdata1", 32'(rdata1), 32'(e.data));
            check("rdata0_hold", 32'(rdata0), 32'(hold0));
            hold1 = rdata1;
          end else begin
            check("rdata0", 32'(rdata0), 32'(e.data));
            check("rdata1_hold", 32'(rdata1), 32'(hold1));
            hold0 = rdata0;
          end
        end
      end
    end
  end

  task automatic drive(input int p, input logic we, input logic [4:0] a, input logic [7:0] d);
    if (p == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic push(input int p, input logic we, input logic [4:0] a, input logic [7:0] d);
    exp_t e;
    if (we) ref_mem[a] = d;
    e.port = p;
    e.data = ref_mem[a];
    sb.push_back(e);
  endtask

  task automatic wait_ack(input int p, output int at);
    logic got;
    got = 1'b0;
    at  = -1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        got = 1'b1;
        at  = cyc;
      end
    end
    check("ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic single(input string tag, input int p, input logic we, input logic [4:0] a,
                        input logic [7:0] d);
    int start, at, w0;
    @(posedge clk); #1;
    start = cyc;
    w0    = we_cnt;
    drive(p, we, a, d);
    push(p, we, a, d);
    wait_ack(p, at);
    check({tag, "_latency"}, 32'(at - start), 32'd2);
    check({tag, "_we_cycles"}, 32'(we_cnt - w0), we ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    if (p == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  initial begin
    int at, start, a1st, g0, g1;
    logic a0s, a1s;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_acks", 32'({ack0, ack1}), 32'd0);
    check("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
    rst_n = 1'b1;

    single("p0_wr5", 0, 1'b1, 5'd5, 8'hA5);
    single("p0_rd5", 0, 1'b0, 5'd5, 8'h00);
    single("p1_wr31", 1, 1'b1, 5'd31, 8'h3C);
    single("p0_rd31", 0, 1'b0, 5'd31, 8'h00);
    check("p0_rd31_value", 32'(rdata0), 32'h3C);

    // Address changes while the access is in flight must not leak into the RAM cycle.
    @(posedge clk); #1;
    drive(0, 1'b0, 5'd3, 8'h00);
    push(0, 1'b0, 5'd3, 8'h00);
    @(posedge clk); #1;
    addr0 = 5'd9;
    check("midchg_ram_addr", 32'(ram_addr), 32'd3);
    wait_ack(0, at);
    @(posedge clk); #1;
    req0 = 1'b0;

    // Asynchronous reset in the ACCESS cycle of a write.
    @(posedge clk); #1;
    drive(0, 1'b1, 5'd7, 8'h77);
    @(posedge clk); #1;
    check("arst_we_before", 32'(ram_we), 32'd1);
    #2;
    rst_n = 1'b0;
    req0  = 1'b0;
    #1;
    check("arst_we", 32'(ram_we), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    check("arst_no_ack", 32'({ack0, ack1}), 32'd0);
    #3;
    rst_n = 1'b1;
    single("post_rst_rd5", 0, 1'b0, 5'd5, 8'h00);

    // Back-to-back reads on port 1 with req held.
    @(posedge clk); #1;
    start = cyc;
    a1st  = 0;
    drive(1, 1'b0, 5'd0, 8'h00);
    for (int k = 0; k < 3; k++) push(1, 1'b0, 5'(k), 8'h00);
    for (int k = 0; k < 3; k++) begin
      wait_ack(1, at);
      if (k == 0) begin
        check("b2b_first", 32'(at - start), 32'd2);
        a1st = at;
      end else begin
        check("b2b_spacing", 32'(at - a1st), 32'(3 * k));
      end
      @(posedge clk); #1;
      check("b2b_idle_busy", 32'(busy), 32'd0);
      if (k < 2) addr1 = 5'(k + 1);
      else req1 = 1'b0;
    end

    // Contention: both ports hold req for four grants each.
    @(posedge clk); #1;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      push(0, 1'b0, 5'(8 + k), 8'h00);
      push(1, 1'b0, 5'(16 + k), 8'h00);
    end
`else
    for (int k = 0; k < 4; k++) push(0, 1'b0, 5'(8 + k), 8'h00);
    for (int k = 0; k < 4; k++) push(1, 1'b0, 5'(16 + k), 8'h00);
`endif
    drive(0, 1'b0, 5'd8, 8'h00);
    drive(1, 1'b0, 5'd16, 8'h00);
    g0 = 0;
    g1 = 0;
    for (int c = 0; c < 60 && (g0 < 4 || g1 < 4); c++) begin
      @(negedge clk);
      a0s = ack0;
      a1s = ack1;
      @(posedge clk); #1;
      if (a0s) begin
        g0++;
        if (g0 < 4) addr0 = 5'(8 + g0);
        else req0 = 1'b0;
      end
      if (a1s) begin
        g1++;
        if (g1 < 4) addr1 = 5'(16 + g1);
        else req1 = 1'b0;
      end
    end
    check("contend_grants0", 32'(g0), 32'd4);
    check("contend_grants1", 32'(g1), 32'd4);
    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
